light_pwm_driver: RTL and testbench
===================================

Name: light_pwm_driver

Overview:
- Consumer of the stand-light FSM's 3-bit light-state output.
- Converts the level (0..4) into an 8-bit PWM duty on a single LED pin.
- Ramps (fades) the duty toward each new level instead of jumping to it.
- Duty changes only at PWM period boundaries, so the LED output never glitches mid-period.

Parameters:
- CLK_DIV, 100, prescaler divide ratio; one PWM counter tick every CLK_DIV clocks; legal range 1..65535.
- RAMP_STEP, 16, duty increment or decrement applied per PWM period while ramping; legal range 1..255.

Ports:
- i_clk  input  1  system clock
- i_reset  input  1  asynchronous, active-high reset
- i_light_state  input  3  requested level from the light FSM; 0..4 legal, 5..7 treated as 4
- o_led  output  1  PWM drive to the LED
- o_duty  output  8  current (ramped) duty value
- o_busy  output  1  high while the duty differs from the target

Behaviour:
- Reset (asynchronous, active-high): the following registers go to 0 immediately and stay there while i_reset is high:
  - prescaler count, pwm_cnt, target, duty_cur
  - o_led=0, o_duty=0, o_busy=0, state=IDLE
- Reset asserted mid-ramp: the ramp is abandoned and duty restarts from 0.
- Input register: i_light_state is registered every clock into lvl_q (1-cycle latency).
- Target mapping (combinational from lvl_q): 0->0, 1->64, 2->128, 3->192, 4..7->255.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 on the cycle the count equals CLK_DIV-1.
  - With CLK_DIV=1, tick is high every cycle.
- PWM counter:
  - pwm_cnt (8-bit) increments on each tick and wraps 255->0.
  - period_end = tick AND pwm_cnt==255.
- Duty update occurs only on period_end:
  - If duty_cur<target: duty_cur = min(duty_cur+RAMP_STEP, target).
  - If duty_cur>target: duty_cur = max(duty_cur-RAMP_STEP, target).
  - Equal: hold.
  - Arithmetic is 9-bit internally; no wrap-around past 0 or 255.
- Ramp state machine, re-evaluated every clock from the registered duty_cur and the current target:
  - IDLE: duty_cur==target.
  - RAMP_UP: duty_cur<target.
  - RAMP_DOWN: duty_cur>target.
  - Direct transitions between any pair of states are legal. A target change mid-ramp reverses direction at the next evaluation.
  - o_busy = (state != IDLE), registered.
  - o_busy rises 2 clocks after an i_light_state change that alters the target.
  - o_busy falls 1 clock after the period_end on which duty_cur reaches target.
- LED output (registered; 1 clock after pwm_cnt/duty_cur):
  - duty_cur==0: o_led=0 constantly.
  - duty_cur==255: o_led=1 constantly.
  - Otherwise: o_led = (pwm_cnt < duty_cur).
- o_duty = duty_cur (direct register output).
- An input change that lands on the same cycle as period_end takes effect at the next period_end, because target is derived from lvl_q.
- Input changes back and forth within one PWM period: only the target present at period_end matters.

Test Plan:
- Bench parameters: CLK_DIV=2, RAMP_STEP=16 (one PWM period = 512 clocks).
- Reset, then hold i_light_state=0 for 2000 clocks -> o_led=0, o_duty=0, o_busy=0 throughout.
- Step 0->2 -> o_busy=1 two clocks later.
  - o_duty goes 16,32,...,128 on 8 consecutive period_ends.
  - o_busy=0 one clock after reaching 128.
  - At steady state o_led is high for 256 of 512 clocks per period.
- Step 0->4 -> ramp reaches 255 after 16 period_ends; the last step is 240->255 (clamped). o_led then stays 1 continuously.
- Settled at 3 (duty 192), step to 1 -> o_duty goes 176,160,...,64 on 8 period_ends, o_busy high during the ramp. A later step to 0 gives 48,32,16,0, after which o_led stays 0.
- Ramping 0->4, switch input to 1 when o_duty=128 -> next period_end gives 112, then 96,80,64, then IDLE. Input 7 behaves identically to 4.
- Assert i_reset mid-ramp at o_duty=96 -> o_duty, o_led, o_busy go to 0 asynchronously, before the next clock edge. After release with input 2, the ramp restarts from 0.

Source files
------------

// File: rtl/light_pwm_driver.sv
// ---------------------------------------------------------------------------
// light_pwm_driver
//
// Turns the stand-light FSM's 3-bit level (0..4, 5..7 read as 4) into an
// 8-bit PWM duty on a single LED pin. The duty fades toward the level's
// target by RAMP_STEP once per PWM period, and only at the period boundary.
// Because of this, a period is never cut short or stretched by a duty change.
//
// Parameters:
//   CLK_DIV   - clocks per PWM counter tick (1..65535)
//   RAMP_STEP - duty change applied per PWM period while ramping (1..255)
//
// Ports:
//   i_clk         - system clock
//   i_reset       - asynchronous, active-high reset
//   i_light_state - requested level from the light FSM
//   o_led         - PWM drive to the LED (registered)
//   o_duty        - current ramped duty (registered)
//   o_busy        - high while the duty differs from the target (registered)
// ---------------------------------------------------------------------------
module light_pwm_driver #(
    parameter int unsigned CLK_DIV   = 32'd100,
    parameter int unsigned RAMP_STEP = 32'd16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_light_state,
    output logic       o_led,
    output logic [7:0] o_duty,
    output logic       o_busy
);

    localparam logic [15:0] PRESC_LAST = 16'(CLK_DIV - 32'd1);
    localparam logic [8:0]  STEP9      = 9'(RAMP_STEP);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RAMP_UP   = 2'b01,
        RAMP_DOWN = 2'b10
    } ramp_state_t;

    logic [2:0]  lvl_r;
    logic [7:0]  target_s;
    logic [15:0] presc_r;
    logic        tick_s;
    logic [7:0]  pwm_cnt_r;
    logic        period_end_s;
    logic [7:0]  duty_r;
    logic [7:0]  duty_next_s;
    logic [8:0]  up_sum_s;
    logic [8:0]  dn_diff_s;
    ramp_state_t state_r;
    ramp_state_t state_next_s;
    logic        busy_r;
    logic        led_r;
    logic        led_next_s;

    // Input register: the level is sampled once per clock.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lvl_r <= 3'd0;
        end else begin
            lvl_r <= i_light_state;
        end
    end

    // Target duty for the registered level; out-of-range levels saturate to full.
    always_comb begin
        target_s = 8'd0;
        case (lvl_r)
            3'd0:    target_s = 8'd0;
            3'd1:    target_s = 8'd64;
            3'd2:    target_s = 8'd128;
            3'd3:    target_s = 8'd192;
            default: target_s = 8'd255;
        endcase
    end

    assign tick_s       = (presc_r == PRESC_LAST);
    assign period_end_s = tick_s && (pwm_cnt_r == 8'd255);

    // Prescaler: free-running 0..CLK_DIV-1; with CLK_DIV=1 it stays at 0 and ticks every clock.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc_r <= 16'd0;
        end else if (tick_s) begin
            presc_r <= 16'd0;
        end else begin
            presc_r <= presc_r + 16'd1;
        end
    end

    // PWM phase counter, advanced once per prescaler tick and wrapping naturally at 255.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pwm_cnt_r <= 8'd0;
        end else if (tick_s) begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
        end else begin
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Next duty: one clamped step toward the target, only at the end of a period.
    // The 9-bit sum/difference exposes overshoot past 255 or below 0 so it clamps instead of wrapping.
    always_comb begin
        duty_next_s = duty_r;
        up_sum_s    = {1'b0, duty_r} + STEP9;
        dn_diff_s   = {1'b0, duty_r} - STEP9;
        if (!period_end_s) begin
            duty_next_s = duty_r;
        end else if (duty_r < target_s) begin
            if (up_sum_s > {1'b0, target_s}) begin
                duty_next_s = target_s;
            end else begin
                duty_next_s = up_sum_s[7:0];
            end
        end else if (duty_r > target_s) begin
            if (dn_diff_s[8] || (dn_diff_s < {1'b0, target_s})) begin
                duty_next_s = target_s;
            end else begin
                duty_next_s = dn_diff_s[7:0];
            end
        end else begin
            duty_next_s = duty_r;
        end
    end

    // Duty register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            duty_r <= 8'd0;
        end else begin
            duty_r <= duty_next_s;
        end
    end

    // Ramp FSM next state: any state may move to any other, decided purely by duty vs target.
    always_comb begin
        state_next_s = state_r;
        if (duty_r == target_s) begin
            state_next_s = IDLE;
        end else if (duty_r < target_s) begin
            state_next_s = RAMP_UP;
        end else begin
            state_next_s = RAMP_DOWN;
        end
    end

    // Ramp FSM state and busy flag; busy is loaded from the next state so it tracks state exactly.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // LED level: the 0 and 255 extremes are forced so they give a solid off/on with no PWM sliver.
    always_comb begin
        led_next_s = 1'b0;
        if (duty_r == 8'd0) begin
            led_next_s = 1'b0;
        end else if (duty_r == 8'd255) begin
            led_next_s = 1'b1;
        end else begin
            led_next_s = (pwm_cnt_r < duty_r);
        end
    end

    // LED output register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            led_r <= 1'b0;
        end else begin
            led_r <= led_next_s;
        end
    end

    assign o_led  = led_r;
    assign o_duty = duty_r;
    assign o_busy = busy_r;

endmodule

// File: tb/tb_light_pwm_driver.sv
// ---------------------------------------------------------------------------
// tb_light_pwm_driver
//
// Directed bench for light_pwm_driver with CLK_DIV=2, RAMP_STEP=16, so one
// PWM period is 512 clocks. Outputs are sampled on the falling clock edge,
// and inputs are driven right after that sample.
// ---------------------------------------------------------------------------
module tb_light_pwm_driver;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [2:0] i_light_state;
    logic       o_led;
    logic [7:0] o_duty;
    logic       o_busy;

    int errors = 0;
    int checks = 0;
    int cnt;
    int bad;

    light_pwm_driver #(
        .CLK_DIV   (32'd2),
        .RAMP_STEP (32'd16)
    ) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_light_state (i_light_state),
        .o_led         (o_led),
        .o_duty        (o_duty),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Wait (bounded) for o_duty to move, then check the new value and optionally
    // that it moved exactly one PWM period (512 clocks) after the call.
    task automatic wait_duty(input string tag, input logic [7:0] exp, input bit check_gap);
        logic [7:0] prev;
        int waited;
        prev = o_duty;
        waited = 0;
        while (o_duty === prev && waited < 1100) begin
            @(negedge i_clk);
            waited++;
        end
        check(tag, 32'(o_duty), 32'(exp));
        if (check_gap) check({tag, "_gap"}, 32'(waited), 32'd512);
    endtask

    // Follow a ramp from 'from' to 'to' in 16-count steps, the last one clamped.
    task automatic ramp(input string tag, input int from, input int to, input bit gap_first);
        int cur;
        bit first;
        cur = from;
        first = 1'b1;
        while (cur != to) begin
            if (to > cur) cur = (cur + 16 > to) ? to : cur + 16;
            else          cur = (cur - 16 < to) ? to : cur - 16;
            wait_duty(tag, 8'(cur), gap_first || !first);
            check({tag, "_busy"}, 32'(o_busy), 32'd1);
            first = 1'b0;
        end
    endtask

    task automatic count_led(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge i_clk);
            if (o_led === 1'b1) c++;
        end
    endtask

    initial begin
        // Reset state
        i_reset = 1'b1;
        i_light_state = 3'd0;
        tick(3);
        check("rst_led",  32'(o_led),  32'd0);
        check("rst_duty", 32'(o_duty), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_reset = 1'b0;

        // Level 0 held: everything stays quiet
        bad = 0;
        repeat (2000) begin
            @(negedge i_clk);
            if (o_led !== 1'b0 || o_duty !== 8'd0 || o_busy !== 1'b0) bad++;
        end
        check("idle_hold", 32'(bad), 32'd0);

        // 0 -> 2: busy after 2 clocks, 8 steps to 128, 50% LED
        i_light_state = 3'd2;
        tick(1);
        check("busy_lat1", 32'(o_busy), 32'd0);
        tick(1);
        check("busy_lat2", 32'(o_busy), 32'd1);
        ramp("up2", 0, 128, 1'b0);
        tick(1);
        check("up2_busy_fall", 32'(o_busy), 32'd0);
        count_led(512, cnt);
        check("led_half", 32'(cnt), 32'd256);

        // 0 -> 4 from a fresh reset: 16 steps, last one 240 -> 255, then LED solid on
        i_reset = 1'b1;
        tick(2);
        i_light_state = 3'd4;
        i_reset = 1'b0;
        ramp("up4", 0, 255, 1'b0);
        tick(1);
        check("up4_busy_fall", 32'(o_busy), 32'd0);
        count_led(600, cnt);
        check("led_full", 32'(cnt), 32'd600);

        // Settle at 3, then down to 1, then down to 0 with LED solid off
        i_light_state = 3'd3;
        ramp("to3", 255, 192, 1'b0);
        tick(1);
        i_light_state = 3'd1;
        ramp("down1", 192, 64, 1'b0);
        tick(1);
        check("down1_busy_fall", 32'(o_busy), 32'd0);
        i_light_state = 3'd0;
        ramp("down0", 64, 0, 1'b0);
        tick(1);
        check("down0_busy_fall", 32'(o_busy), 32'd0);
        count_led(600, cnt);
        check("led_off", 32'(cnt), 32'd0);

        // Reversal: heading for 255, switch to level 1 at 128 -> 112 at the very next period end
        i_light_state = 3'd4;
        ramp("rev_up", 0, 128, 1'b0);
        i_light_state = 3'd1;
        ramp("rev_down", 128, 64, 1'b1);
        tick(1);
        check("rev_busy_fall", 32'(o_busy), 32'd0);

        // Level 7 saturates like level 4
        i_light_state = 3'd7;
        ramp("in7", 64, 255, 1'b0);
        tick(1);
        check("in7_busy_fall", 32'(o_busy), 32'd0);
        check("in7_led", 32'(o_led), 32'd1);

        // Reset mid-ramp at 96: outputs clear before the next clock edge
        i_reset = 1'b1;
        tick(2);
        i_light_state = 3'd4;
        i_reset = 1'b0;
        ramp("pre_rst", 0, 96, 1'b0);
        tick(10);
        check("pre_rst_led", 32'(o_led), 32'd1);
        i_reset = 1'b1;
        #1;
        check("async_duty", 32'(o_duty), 32'd0);
        check("async_led",  32'(o_led),  32'd0);
        check("async_busy", 32'(o_busy), 32'd0);
        tick(3);
        i_light_state = 3'd2;
        i_reset = 1'b0;
        // First period end falls exactly 512 clocks after release; ramp restarts from 0
        wait_duty("restart", 8'd16, 1'b1);
        check("restart_busy", 32'(o_busy), 32'd1);
        ramp("restart_up", 16, 128, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
